// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register with execution engine.
//   opcode_t : 4-bit instruction opcode (ZERO..MOD, 8..15 unused)
//   instr_t  : one stored instruction word {opc, a, b}
//   result_t : signed result of one executed instruction
// IR_OP_W fixes the operand width carried by instr_t; blocks importing this package
// default their OP_W parameter to it and must keep the two equal.
package instr_register_pkg;

    localparam int unsigned IR_OP_W  = 32;
    localparam int unsigned IR_RES_W = 2 * IR_OP_W;

    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [IR_OP_W-1:0]  operand_t;
    typedef logic signed [IR_RES_W-1:0] result_t;

    typedef struct packed {
        opcode_t  opc;
        operand_t a;
        operand_t b;
    } instr_t;

endpackage

// File: rtl/instr_alu.sv
// Combinational arithmetic unit for one instruction.
//   opc_i : opcode
//   a_i   : signed operand A
//   b_i   : signed operand B
//   res_o : signed result, RES_W = 2*OP_W bits
//   err_o : divide or modulo by zero (res_o forced to 0)
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int unsigned OP_W = IR_OP_W,
    localparam int unsigned RES_W = 2 * OP_W
) (
    input  opcode_t                 opc_i,
    input  logic signed [OP_W-1:0]  a_i,
    input  logic signed [OP_W-1:0]  b_i,
    output logic signed [RES_W-1:0] res_o,
    output logic                    err_o
);

    logic signed [RES_W-1:0] a_x;
    logic signed [RES_W-1:0] b_x;
    logic                    b_zero;

    // Everything is evaluated at full result width, so ADD/SUB/MULT are exact and
    // DIV of the most negative value by -1 does not overflow.
    always_comb begin
        a_x    = RES_W'(a_i);
        b_x    = RES_W'(b_i);
        b_zero = (b_i == '0);
        res_o  = '0;
        err_o  = 1'b0;
        unique case (opc_i)
            ZERO:  res_o = '0;
            PASSA: res_o = a_x;
            PASSB: res_o = b_x;
            ADD:   res_o = a_x + b_x;
            SUB:   res_o = a_x - b_x;
            MULT:  res_o = a_x * b_x;
            DIV: begin
                if (b_zero) err_o = 1'b1;
                else        res_o = a_x / b_x;
            end
            MOD: begin
                if (b_zero) err_o = 1'b1;
                else        res_o = a_x % b_x;
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_exec.sv
// Instruction register with a sweeping execution engine.
// Stores DEPTH instruction words and, on request, executes a run of exec_count entries
// starting at exec_base (wrapping modulo DEPTH), one result per entry, 3 cycles each.
//   clk, reset        : clock, synchronous active-high reset
//   load_en, write_pointer, opcode, operand_a, operand_b : instruction write port
//   read_pointer, instruction_word : debug read port, 1-cycle latency, read-before-write
//   exec_start, exec_base, exec_count : sweep request (sampled only when idle)
//   exec_busy         : engine not idle
//   res_valid/res_ready, res_data, res_addr, res_err : result handshake
//   done              : one-cycle pulse after the last result of a sweep is accepted
//                       (also for a zero-length request)
module instr_register_exec
    import instr_register_pkg::*;
#(
    parameter int unsigned OP_W  = IR_OP_W,
    parameter int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned RES_W = 2 * OP_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_en,
    input  logic [AW-1:0]           write_pointer,
    input  opcode_t                 opcode,
    input  logic signed [OP_W-1:0]  operand_a,
    input  logic signed [OP_W-1:0]  operand_b,
    input  logic [AW-1:0]           read_pointer,
    output instr_t                  instruction_word,
    input  logic                    exec_start,
    input  logic [AW-1:0]           exec_base,
    input  logic [AW:0]             exec_count,
    output logic                    exec_busy,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [RES_W-1:0] res_data,
    output logic [AW-1:0]           res_addr,
    output logic                    res_err,
    output logic                    done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StHold,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // Instruction storage and debug read
    // ------------------------------------------------------------------
    instr_t mem_q [DEPTH];
    instr_t instr_word_q;

    // Reads sample mem_q before this edge's write lands, so a same-cycle write to the
    // read address returns the old word (debug port and FETCH alike).
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q        <= '{default: '0};
            instr_word_q <= '0;
        end else begin
            if (load_en) begin
                mem_q[write_pointer] <= '{opc: opcode, a: operand_a, b: operand_b};
            end
            instr_word_q <= mem_q[read_pointer];
        end
    end

    assign instruction_word = instr_word_q;

    // ------------------------------------------------------------------
    // Execution engine
    // ------------------------------------------------------------------
    state_e                  state_q, state_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [AW:0]             rem_q, rem_d;
    instr_t                  fetch_q, fetch_d;
    logic signed [RES_W-1:0] res_data_q, res_data_d;
    logic [AW-1:0]           res_addr_q, res_addr_d;
    logic                    res_err_q, res_err_d;
    logic                    res_valid_q, res_valid_d;
    logic                    done_q, done_d;

    logic signed [RES_W-1:0] alu_res;
    logic                    alu_err;

    instr_alu #(
        .OP_W (OP_W)
    ) u_alu (
        .opc_i (fetch_q.opc),
        .a_i   (fetch_q.a),
        .b_i   (fetch_q.b),
        .res_o (alu_res),
        .err_o (alu_err)
    );

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rem_d       = rem_q;
        fetch_d     = fetch_q;
        res_data_d  = res_data_q;
        res_addr_d  = res_addr_q;
        res_err_d   = res_err_q;
        res_valid_d = res_valid_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (exec_start) begin
                    if (exec_count == '0) begin
                        // Empty sweep: acknowledge immediately without leaving idle.
                        done_d = 1'b1;
                    end else begin
                        ptr_d   = exec_base;
                        rem_d   = exec_count;
                        state_d = StFetch;
                    end
                end
            end
            StFetch: begin
                fetch_d = mem_q[ptr_q];
                state_d = StExec;
            end
            StExec: begin
                res_data_d  = alu_res;
                res_err_d   = alu_err;
                res_addr_d  = ptr_q;
                res_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    rem_d       = rem_q - (AW + 1)'(1);
                    // DEPTH is a power of two, so the natural AW-bit overflow is the wrap.
                    ptr_d       = ptr_q + AW'(1);
                    if (rem_q == (AW + 1)'(1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            rem_q       <= '0;
            fetch_q     <= '0;
            res_data_q  <= '0;
            res_addr_q  <= '0;
            res_err_q   <= 1'b0;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rem_q       <= rem_d;
            fetch_q     <= fetch_d;
            res_data_q  <= res_data_d;
            res_addr_q  <= res_addr_d;
            res_err_q   <= res_err_d;
            res_valid_q <= res_valid_d;
            done_q      <= done_d;
        end
    end

    assign exec_busy = (state_q != StIdle);
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_addr  = res_addr_q;
    assign res_err   = res_err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_instr_register_exec.sv
// Scoreboard bench for instr_register_exec (DEPTH=8). Stimulus pushes the expected
// results; a negedge monitor compares them whenever res_valid is high and pops on accept.
module tb_instr_register_exec;
    import instr_register_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               load_en;
    logic [AW-1:0]      write_pointer;
    opcode_t            opcode;
    logic signed [31:0] operand_a;
    logic signed [31:0] operand_b;
    logic [AW-1:0]      read_pointer;
    instr_t             instruction_word;
    logic               exec_start;
    logic [AW-1:0]      exec_base;
    logic [AW:0]        exec_count;
    logic               exec_busy;
    logic               res_valid;
    logic               res_ready;
    logic signed [63:0] res_data;
    logic [AW-1:0]      res_addr;
    logic               res_err;
    logic               done;

    instr_register_exec #(
        .DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .exec_start       (exec_start),
        .exec_base        (exec_base),
        .exec_count       (exec_count),
        .exec_busy        (exec_busy),
        .res_valid        (res_valid),
        .res_ready        (res_ready),
        .res_data         (res_data),
        .res_addr         (res_addr),
        .res_err          (res_err),
        .done             (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [63:0] data;
        logic [AW-1:0]      addr;
        logic               err;
    } exp_t;

    exp_t sb[$];
    int   n_checks     = 0;
    int   n_fail       = 0;
    int   done_cnt     = 0;
    int   cyc          = 0;
    int   last_acc_cyc = 0;
    bit   acc_seen     = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare the held result against the scoreboard head every valid cycle,
    // pop when the handshake completes, and time-check each done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 80'(sb.size()), 80'd1);
                end else begin
                    chk("res_data", res_data, sb[0].data);
                    chk("res_addr", res_addr, sb[0].addr);
                    chk("res_err", res_err, sb[0].err);
                    if (res_ready) begin
                        void'(sb.pop_front());
                        last_acc_cyc = cyc;
                        acc_seen     = 1'b1;
                    end
                end
            end
            if (done) begin
                done_cnt++;
                if (acc_seen) chk("done_after_accept", 80'(cyc), 80'(last_acc_cyc + 1));
                acc_seen = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int unsigned addr, input opcode_t o, input int a, input int b);
        load_en       = 1'b1;
        write_pointer = AW'(addr);
        opcode        = o;
        operand_a     = a;
        operand_b     = b;
        tick();
        load_en = 1'b0;
    endtask

    task automatic expect_res(input longint d, input int unsigned addr, input bit e);
        exp_t x;
        x.data = d;
        x.addr = AW'(addr);
        x.err  = e;
        sb.push_back(x);
    endtask

    task automatic run(input int unsigned base, input int unsigned count);
        exec_base  = AW'(base);
        exec_count = (AW + 1)'(count);
        exec_start = 1'b1;
        tick();
        exec_start = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        chk("valid_seen", res_valid, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exec_busy && n < 100) begin
            tick();
            n++;
        end
        chk("sweep_finished", exec_busy, 1'b0);
    endtask

    initial begin
        instr_t e;
        int     d0;
        int     n;

        reset         = 1'b1;
        load_en       = 1'b0;
        write_pointer = '0;
        opcode        = ZERO;
        operand_a     = '0;
        operand_b     = '0;
        read_pointer  = '0;
        exec_start    = 1'b0;
        exec_base     = '0;
        exec_count    = '0;
        res_ready     = 1'b0;
        tick();
        tick();
        reset        = 1'b0;
        read_pointer = AW'(5);
        tick();

        // Reset state
        e = '{opc: ZERO, a: 0, b: 0};
        chk("reset_word", instruction_word, e);
        chk("reset_valid", res_valid, 1'b0);
        chk("reset_busy", exec_busy, 1'b0);
        chk("reset_done", done, 1'b0);

        // Same-cycle write and read of entry 5 returns the old word, then the new one
        load(5, PASSA, 11, 0);
        chk("rd_during_wr_old", instruction_word, e);
        tick();
        e = '{opc: PASSA, a: 11, b: 0};
        chk("rd_after_wr_new", instruction_word, e);

        // Single ADD, latency and done pulse
        load(3, ADD, 7, -2);
        read_pointer = AW'(3);
        tick();
        e = '{opc: ADD, a: 7, b: -2};
        chk("debug_read_3", instruction_word, e);
        expect_res(5, 3, 1'b0);
        res_ready  = 1'b1;
        d0         = done_cnt;
        exec_base  = AW'(3);
        exec_count = (AW + 1)'(1);
        exec_start = 1'b1;
        n          = 0;
        do begin
            tick();
            exec_start = 1'b0;
            n++;
        end while (!res_valid && n < 20);
        chk("first_valid_latency", 80'(n), 80'd3);
        wait_idle();
        chk("add_done_count", 80'(done_cnt - d0), 80'd1);

        // Backpressure: result must stay stable while ready is low
        load(0, MULT, -40000, 40000);
        res_ready = 1'b0;
        expect_res(-64'sd1600000000, 0, 1'b0);
        d0 = done_cnt;
        run(0, 1);
        wait_valid();
        repeat (5) begin
            tick();
            chk("bp_valid_held", res_valid, 1'b1);
        end
        res_ready = 1'b1;
        wait_idle();
        chk("bp_done_count", 80'(done_cnt - d0), 80'd1);

        // Divide by zero then a signed modulo
        load(2, DIV, 9, 0);
        load(3, MOD, -7, 2);
        expect_res(0, 2, 1'b1);
        expect_res(-1, 3, 1'b0);
        d0 = done_cnt;
        run(2, 2);
        wait_idle();
        chk("div_done_count", 80'(done_cnt - d0), 80'd1);

        // Wrap-around 6,7,0,1 with a start request while busy that must be ignored
        load(6, ADD, 100, 1);
        load(7, SUB, 5, 10);
        load(0, PASSB, 0, -9);
        load(1, PASSA, -3, 0);
        expect_res(101, 6, 1'b0);
        expect_res(-5, 7, 1'b0);
        expect_res(-9, 0, 1'b0);
        expect_res(-3, 1, 1'b0);
        d0 = done_cnt;
        run(6, 4);
        tick();
        run(4, 1);
        wait_idle();
        chk("wrap_done_count", 80'(done_cnt - d0), 80'd1);
        chk("wrap_sb_empty", 80'(sb.size()), 80'd0);

        // Zero-length request: done pulse, never busy
        d0 = done_cnt;
        run(0, 0);
        chk("zero_count_busy", exec_busy, 1'b0);
        tick();
        tick();
        chk("zero_count_done", 80'(done_cnt - d0), 80'd1);

        // Reset while holding a result
        load(4, ADD, 1, 1);
        res_ready = 1'b0;
        expect_res(2, 4, 1'b0);
        d0 = done_cnt;
        run(4, 1);
        wait_valid();
        reset = 1'b1;
        tick();
        chk("rst_mid_valid", res_valid, 1'b0);
        chk("rst_mid_busy", exec_busy, 1'b0);
        reset = 1'b0;
        sb.delete();
        res_ready = 1'b1;
        repeat (6) tick();
        chk("rst_mid_no_done", 80'(done_cnt - d0), 80'd0);
        chk("rst_mid_idle", exec_busy, 1'b0);

        chk("final_sb_empty", 80'(sb.size()), 80'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
